logic_unit_pipe: RTL

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - bitwise logic unit with one output register plus one skid register
module logic_unit_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_ones
);

    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             res_ones;

    always_comb begin
        res = '0;
        unique case (in_op)
            3'd0: res = in_a & in_b;
            3'd1: res = in_a | in_b;
            3'd2: res = in_a ^ in_b;
            3'd3: res = ~(in_a | in_b);
            3'd4: res = ~(in_a & in_b);
            3'd5: res = ~(in_a ^ in_b);
            3'd6: res = in_a & ~in_b;
            3'd7: res = in_a | ~in_b;
            default: res = '0;
        endcase
    end

    // Flags come from the unregistered result so they are ready alongside it.
    assign res_zero = ~|res;
    assign res_ones = &res;

    logic             or_full;
    logic [WIDTH-1:0] or_data;
    logic [TAG_W-1:0] or_tag;
    logic             or_zero;
    logic             or_ones;

    logic             sk_full;
    logic [WIDTH-1:0] sk_data;
    logic [TAG_W-1:0] sk_tag;
    logic             sk_zero;
    logic             sk_ones;

    logic in_fire;
    logic out_fire;

    assign in_ready  = ~sk_full & ~rst;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = or_full & out_ready;

    assign out_valid = or_full;
    assign out_data  = or_data;
    assign out_tag   = or_tag;
    assign out_zero  = or_zero;
    assign out_ones  = or_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            or_full <= 1'b0;
            or_data <= '0;
            or_tag  <= '0;
            or_zero <= 1'b0;
            or_ones <= 1'b0;
            sk_full <= 1'b0;
            sk_data <= '0;
            sk_tag  <= '0;
            sk_zero <= 1'b0;
            sk_ones <= 1'b0;
        end else if (out_fire) begin
            if (sk_full) begin
                // in_ready is low while the skid is full, so no new bundle competes here.
                or_data <= sk_data;
                or_tag  <= sk_tag;
                or_zero <= sk_zero;
                or_ones <= sk_ones;
                sk_full <= 1'b0;
            end else if (in_fire) begin
                or_data <= res;
                or_tag  <= in_tag;
                or_zero <= res_zero;
                or_ones <= res_ones;
            end else begin
                or_full <= 1'b0;
            end
        end else if (in_fire) begin
            if (!or_full) begin
                or_full <= 1'b1;
                or_data <= res;
                or_tag  <= in_tag;
                or_zero <= res_zero;
                or_ones <= res_ones;
            end else begin
                sk_full <= 1'b1;
                sk_data <= res;
                sk_tag  <= in_tag;
                sk_zero <= res_zero;
                sk_ones <= res_ones;
            end
        end
    end

endmodule
